// File: rtl/zbt_proc_writer.sv
// rtl/zbt_proc_writer.sv - ZBT bank 1 slot mux, capture FSM and write-data pipe
// Odd hcount slots write processed pixels, even slots carry the display read address.
module zbt_proc_writer #(
  parameter int ACTIVE_LINES = 768,
  parameter int WDATA_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [35:0] two_proc_pixs,
  input  logic [18:0] proc_pix_addr,
  input  logic [18:0] disp_read_addr,
  input  logic        capture,
  input  logic        continuous,
  output logic [18:0] zbt_addr,
  output logic        zbt_we,
  output logic [35:0] zbt_write_data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam logic [9:0] LINE_LIMIT = 10'(ACTIVE_LINES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   cap_prev_q, cap_prev_d;
  logic   frame_done_q, frame_done_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic [18:0] zbt_addr_q, zbt_addr_d;
  logic        zbt_we_q, zbt_we_d;
  logic [35:0] zbt_write_data_q, zbt_write_data_d;
  logic [WDATA_LAT-1:0][35:0] pipe_q, pipe_d;
  logic [WDATA_LAT-1:0]       vld_q, vld_d;

  logic fs;
  logic cap_rise;
  logic slot_odd;
  logic line_ok;

  assign fs       = (hcount == 11'd0) && (vcount == 10'd0);
  assign cap_rise = capture && !cap_prev_q;
  assign slot_odd = hcount[0];
  assign line_ok  = proc_pix_addr[18:9] < LINE_LIMIT;

  // Capture edges outside IDLE fall through untouched, so they are never queued.
  always_comb begin
    state_d       = state_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    cap_prev_d    = capture;
    case (state_q)
      IDLE: begin
        if (cap_rise || continuous) state_d = ARMED;
      end
      ARMED: begin
        if (fs) state_d = WRITE;
      end
      WRITE: begin
        if (fs) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          state_d       = continuous ? WRITE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    zbt_addr_d       = slot_odd ? proc_pix_addr : disp_read_addr;
    zbt_we_d         = slot_odd && (state_q == WRITE) && line_ok;
    pipe_d           = pipe_q;
    vld_d            = '0;
    zbt_write_data_d = zbt_write_data_q;
    if (slot_odd) pipe_d[0] = two_proc_pixs;
    vld_d[0] = zbt_we_d;
    for (int i = 1; i < WDATA_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
      vld_d[i]  = vld_q[i-1];
    end
    // Only a valid write updates the output word; otherwise it holds.
    if (vld_q[WDATA_LAT-1]) zbt_write_data_d = pipe_q[WDATA_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cap_prev_q       <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_count_q    <= 8'd0;
      zbt_addr_q       <= 19'd0;
      zbt_we_q         <= 1'b0;
      zbt_write_data_q <= 36'd0;
      pipe_q           <= '0;
      vld_q            <= '0;
    end else begin
      state_q          <= state_d;
      cap_prev_q       <= cap_prev_d;
      frame_done_q     <= frame_done_d;
      frame_count_q    <= frame_count_d;
      zbt_addr_q       <= zbt_addr_d;
      zbt_we_q         <= zbt_we_d;
      zbt_write_data_q <= zbt_write_data_d;
      pipe_q           <= pipe_d;
      vld_q            <= vld_d;
    end
  end

  assign zbt_addr       = zbt_addr_q;
  assign zbt_we         = zbt_we_q;
  assign zbt_write_data = zbt_write_data_q;
  assign busy           = (state_q != IDLE);
  assign frame_done     = frame_done_q;
  assign frame_count    = frame_count_q;

endmodule
